noc_flit_receiver: RTL



---
 rtl/noc_pkg.sv | 20 ++
 rtl/noc_vc_fifo.sv | 63 ++++++
 rtl/noc_flit_receiver.sv | 121 ++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - flit and credit field layout shared by the NoC receive port.
package noc_pkg;
  localparam int FLIT_W         = 71;
  localparam int DATA_W         = 64;
  localparam int DEST_W         = 4;
  localparam int FLIT_VALID_BIT = 70;
  localparam int FLIT_TAIL_BIT  = 69;
  localparam int FLIT_DEST_HI   = 68;
  localparam int FLIT_DEST_LO   = 65;
  localparam int FLIT_VC_BIT    = 64;

  localparam int CREDIT_W         = 2;
  localparam int CREDIT_VALID_BIT = 1;
  localparam int CREDIT_VC_BIT    = 0;

  // Buffered entry keeps the tail bit above the payload.
  localparam int ENTRY_W = DATA_W + 1;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;
endpackage

// File: rtl/noc_vc_fifo.sv
// rtl/noc_vc_fifo.sv - per-VC flit buffer; caller only enqueues when !full or dequeuing.
module noc_vc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enq,
  input  logic [WIDTH-1:0] enq_data,
  input  logic             deq,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) begin
      mem_d[wr_ptr_q] = enq_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (deq) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: rtl/noc_flit_receiver.sv
// rtl/noc_flit_receiver.sv - NoC receive port: per-VC buffering, packet-locked
// round-robin delivery and one-cycle-delayed credit return.
module noc_flit_receiver
  import noc_pkg::*;
#(
  parameter logic [3:0] MY_NODE_ID = 4'd0,
  parameter int         VC_DEPTH   = 4,
  parameter int         NUM_VCS    = 2
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [FLIT_W-1:0]   flit_in,
  output logic                en_get_flit,
  output logic [CREDIT_W-1:0] credit_out,
  output logic                en_put_credits,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_vc,
  output logic                out_tail,
  output logic                err_overflow,
  output logic                err_misroute
);
  logic [NUM_VCS-1:0] fifo_full, fifo_empty, fifo_enq, fifo_deq;
  logic [ENTRY_W-1:0] fifo_head [NUM_VCS];

  arb_state_e          state_q, state_d;
  logic                lock_vc_q, lock_vc_d;
  logic                park_q, park_d;
  logic                rr_q, rr_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                err_overflow_q, err_overflow_d;
  logic                err_misroute_q, err_misroute_d;

  logic in_valid, in_vc, sel_vc, deq;

  assign in_valid = RST_N & flit_in[FLIT_VALID_BIT];
  assign in_vc    = flit_in[FLIT_VC_BIT];

  for (genvar g = 0; g < NUM_VCS; g++) begin : g_vc
    assign fifo_deq[g] = deq && (sel_vc == 1'(g));
    assign fifo_enq[g] = in_valid && (in_vc == 1'(g)) && (!fifo_full[g] || fifo_deq[g]);

    noc_vc_fifo #(.DEPTH(VC_DEPTH), .WIDTH(ENTRY_W)) u_fifo (
      .clk      (CLK),
      .rst_n    (RST_N),
      .enq      (fifo_enq[g]),
      .enq_data ({flit_in[FLIT_TAIL_BIT], flit_in[DATA_W-1:0]}),
      .deq      (fifo_deq[g]),
      .full     (fifo_full[g]),
      .empty    (fifo_empty[g]),
      .head     (fifo_head[g])
    );
  end

  // A flit already shown to a stalled consumer pins the selection (park) so a
  // late arrival on the round-robin favourite cannot swap the output under it.
  always_comb begin
    if (state_q == ARB_LOCKED || park_q) sel_vc = lock_vc_q;
    else if (!fifo_empty[rr_q])          sel_vc = rr_q;
    else                                 sel_vc = ~rr_q;
  end

  assign out_valid              = RST_N & ~fifo_empty[sel_vc];
  assign {out_tail, out_data}   = fifo_head[sel_vc];
  assign out_vc                 = sel_vc;
  assign deq                    = out_valid & out_ready;

  always_comb begin
    state_d   = state_q;
    lock_vc_d = lock_vc_q;
    park_d    = park_q;
    rr_d      = rr_q;
    if (deq) begin
      park_d = 1'b0;
      if (out_tail) begin
        state_d = ARB_IDLE;
        rr_d    = ~sel_vc;
      end else begin
        state_d   = ARB_LOCKED;
        lock_vc_d = sel_vc;
      end
    end else if (out_valid && state_q == ARB_IDLE) begin
      park_d    = 1'b1;
      lock_vc_d = sel_vc;
    end
  end

  always_comb begin
    credit_d       = deq ? {1'b1, sel_vc} : '0;
    err_overflow_d = err_overflow_q | (in_valid & fifo_full[in_vc] & ~fifo_deq[in_vc]);
    err_misroute_d = err_misroute_q |
                     (in_valid & (flit_in[FLIT_DEST_HI:FLIT_DEST_LO] != MY_NODE_ID));
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q        <= ARB_IDLE;
      lock_vc_q      <= 1'b0;
      park_q         <= 1'b0;
      rr_q           <= 1'b0;
      credit_q       <= '0;
      err_overflow_q <= 1'b0;
      err_misroute_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      lock_vc_q      <= lock_vc_d;
      park_q         <= park_d;
      rr_q           <= rr_d;
      credit_q       <= credit_d;
      err_overflow_q <= err_overflow_d;
      err_misroute_q <= err_misroute_d;
    end
  end

  assign en_get_flit    = RST_N;
  assign credit_out     = RST_N ? credit_q : '0;
  assign en_put_credits = credit_out[CREDIT_VALID_BIT];
  assign err_overflow   = err_overflow_q;
  assign err_misroute   = err_misroute_q;
endmodule
